// File: rtl/rv32i_wb_arb.sv
// Write-back arbiter for the RV32I register file: round-robin grant of the single write port
// among NREQ producers, registered write port, and a pending-write scoreboard for RAW stalls.
module rv32i_wb_arb #(
    parameter int unsigned NREQ = 3
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              WB_EN,
    input  logic [NREQ-1:0]   REQ_VALID,
    output logic [NREQ-1:0]   REQ_READY,
    input  logic [NREQ*5-1:0] REQ_ADDR,
    input  logic [NREQ*32-1:0] REQ_DATA,
    output logic              WE,
    output logic [4:0]        WADDR,
    output logic [31:0]       WDATA,
    input  logic              SB_SET,
    input  logic [4:0]        SB_SET_ADDR,
    output logic [31:0]       BUSY
);

    localparam int unsigned PtrW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [PtrW-1:0] LastIdx = PtrW'(NREQ - 1);

    logic [PtrW-1:0] r_ptr;
    logic            r_we;
    logic [4:0]      r_waddr;
    logic [31:0]     r_wdata;
    logic [31:0]     r_busy;

    logic [4:0]      w_addr_arr [NREQ];
    logic [31:0]     w_data_arr [NREQ];
    logic [NREQ-1:0] w_ready;
    logic            w_xfer;
    logic [PtrW-1:0] w_gidx;
    logic [PtrW-1:0] w_scan;
    logic [PtrW-1:0] w_ptr_d;
    logic [31:0]     w_busy_d;

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign w_addr_arr[g] = REQ_ADDR[5*g +: 5];
        assign w_data_arr[g] = REQ_DATA[32*g +: 32];
    end

    // Round-robin scan starting at r_ptr; first valid requester wins.
    always_comb begin
        w_ready = '0;
        w_xfer  = 1'b0;
        w_gidx  = '0;
        w_scan  = '0;
        if (WB_EN && !RST) begin
            for (int unsigned k = 0; k < NREQ; k++) begin
                w_scan = PtrW'((32'(r_ptr) + k) % NREQ);
                if (!w_xfer && REQ_VALID[w_scan]) begin
                    w_ready[w_scan] = 1'b1;
                    w_xfer          = 1'b1;
                    w_gidx          = w_scan;
                end
            end
        end
    end

    assign w_ptr_d = (w_gidx == LastIdx) ? '0 : w_gidx + 1'b1;

    // A set in the same cycle as the commit belongs to a newer write, so it wins.
    always_comb begin
        w_busy_d = r_busy;
        if (WE) begin
            w_busy_d[r_waddr] = 1'b0;
        end
        if (SB_SET && (SB_SET_ADDR != 5'd0)) begin
            w_busy_d[SB_SET_ADDR] = 1'b1;
        end
        w_busy_d[0] = 1'b0;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_ptr   <= '0;
            r_we    <= 1'b0;
            r_waddr <= 5'd0;
            r_wdata <= 32'd0;
            r_busy  <= 32'd0;
        end else begin
            r_we   <= w_xfer && (w_addr_arr[w_gidx] != 5'd0);
            r_busy <= w_busy_d;
            if (w_xfer) begin
                r_ptr   <= w_ptr_d;
                r_waddr <= w_addr_arr[w_gidx];
                r_wdata <= w_data_arr[w_gidx];
            end
        end
    end

    assign REQ_READY = w_ready;
    // Reset discards a write still sitting in the output register.
    assign WE        = r_we & ~RST;
    assign WADDR     = r_waddr;
    assign WDATA     = r_wdata;
    assign BUSY      = r_busy;

endmodule
